// File: rtl/cart_bus_master_if.sv
// DMG cartridge bus bundle: CPU-side req/ack handshake plus the cartridge slot
// signals. master = cart_bus_master, slave = requester and cartridge models.
interface cart_bus_master_if;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        ack;
   logic [7:0]  rdata;
   logic        busy;
   logic [15:0] a;
   logic [7:0]  d_out;
   logic        d_oe;
   logic [7:0]  d_in;
   logic        nrd;
   logic        nwr;
   logic        ncs;

   modport master (
      input  req, we, addr, wdata, d_in,
      output ack, rdata, busy, a, d_out, d_oe, nrd, nwr, ncs
   );

   modport slave (
      output req, we, addr, wdata, d_in,
      input  ack, rdata, busy, a, d_out, d_oe, nrd, nwr, ncs
   );
endinterface

// File: rtl/cart_bus_master.sv
// DMG cartridge bus initiator: one req/ack transaction becomes one timed
// IDLE->ADDR->STRB->HOLD bus cycle. Optional macro CART_RD_IDLE_EN: read-biased idle nrd.
module cart_bus_master #(
   parameter int unsigned STROBE_CYCLES = 2
) (
   input logic               clk,
   input logic               nrst,
   cart_bus_master_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_STRB = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   localparam logic [3:0] STRB_LOAD = 4'(STROBE_CYCLES - 1);

`ifdef CART_RD_IDLE_EN
   localparam logic NRD_IDLE = 1'b0;
`else
   localparam logic NRD_IDLE = 1'b1;
`endif

   state_t      state_r;
   logic        we_r;
   logic [3:0]  cnt_r;
   logic [15:0] a_r;
   logic [7:0]  d_out_r;
   logic        d_oe_r;
   logic [7:0]  rdata_r;
   logic        nrd_r;
   logic        nwr_r;
   logic        ncs_r;
   logic        ack_r;
   logic        busy_r;
   logic        ram_hit_s;

   // External RAM / WRAM-echo window that needs ncs
   assign ram_hit_s = (a_r >= 16'hA000) && (a_r <= 16'hFDFF);

   // Bus-cycle sequencer; every output is a register updated here
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_r <= ST_IDLE;
         we_r    <= 1'b0;
         cnt_r   <= 4'd0;
         a_r     <= 16'h0000;
         d_out_r <= 8'h00;
         d_oe_r  <= 1'b0;
         rdata_r <= 8'h00;
         nrd_r   <= 1'b1;
         nwr_r   <= 1'b1;
         ncs_r   <= 1'b1;
         ack_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ack_r <= 1'b0;
               if (bus.req) begin
                  a_r    <= bus.addr;
                  we_r   <= bus.we;
                  d_oe_r <= bus.we;
                  if (bus.we) begin
                     d_out_r <= bus.wdata;
                  end else begin
                     d_out_r <= d_out_r;
                  end
                  // A write lifts a read-biased idle nrd before the strobe
                  nrd_r   <= NRD_IDLE | bus.we;
                  busy_r  <= 1'b1;
                  state_r <= ST_ADDR;
               end else begin
                  nrd_r   <= NRD_IDLE;
                  state_r <= ST_IDLE;
               end
            end
            ST_ADDR: begin
               cnt_r   <= STRB_LOAD;
               nrd_r   <= we_r;
               nwr_r   <= ~we_r;
               ncs_r   <= ~ram_hit_s;
               state_r <= ST_STRB;
            end
            ST_STRB: begin
               if (cnt_r == 4'd0) begin
                  nrd_r   <= NRD_IDLE | we_r;
                  nwr_r   <= 1'b1;
                  ncs_r   <= 1'b1;
                  ack_r   <= 1'b1;
                  if (!we_r) begin
                     rdata_r <= bus.d_in;
                  end else begin
                     rdata_r <= rdata_r;
                  end
                  state_r <= ST_HOLD;
               end else begin
                  cnt_r   <= cnt_r - 4'd1;
                  state_r <= ST_STRB;
               end
            end
            ST_HOLD: begin
               ack_r   <= 1'b0;
               d_oe_r  <= 1'b0;
               busy_r  <= 1'b0;
               nrd_r   <= NRD_IDLE;
               state_r <= ST_IDLE;
            end
            default: begin
               ack_r   <= 1'b0;
               d_oe_r  <= 1'b0;
               busy_r  <= 1'b0;
               nrd_r   <= 1'b1;
               nwr_r   <= 1'b1;
               ncs_r   <= 1'b1;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.a     = a_r;
   assign bus.d_out = d_out_r;
   assign bus.d_oe  = d_oe_r;
   assign bus.rdata = rdata_r;
   assign bus.nrd   = nrd_r;
   assign bus.nwr   = nwr_r;
   assign bus.ncs   = ncs_r;
   assign bus.ack   = ack_r;
   assign bus.busy  = busy_r;

endmodule

// File: tb/tb_cart_bus_master.sv
// Directed bench for cart_bus_master: cycle checks on a 2-strobe instance with
// a small MBC1 responder, plus a 1-strobe instance for back-to-back reads.
module tb_cart_bus_master;

`ifdef CART_RD_IDLE_EN
   localparam logic NRD_IDLE = 1'b0;
`else
   localparam logic NRD_IDLE = 1'b1;
`endif

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  rdata;
   } exp_t;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];

   logic       mbc_en = 1'b0;
   logic [7:0] din_v  = 8'h00;
   logic [4:0] bank_r = 5'd1;

   always #5 clk = ~clk;

   cart_bus_master_if bus0 ();
   cart_bus_master_if bus1 ();

   cart_bus_master #(.STROBE_CYCLES(2)) dut0 (.clk(clk), .nrst(nrst), .bus(bus0.master));
   cart_bus_master #(.STROBE_CYCLES(1)) dut1 (.clk(clk), .nrst(nrst), .bus(bus1.master));

   // MBC1 ROM bank register: writes to 0x2000..0x3FFF, bank 0 maps to 1
   always @(posedge clk) begin
      if (bus0.nwr === 1'b0 && bus0.a >= 16'h2000 && bus0.a <= 16'h3FFF)
         bank_r <= (bus0.d_out[4:0] == 5'd0) ? 5'd1 : bus0.d_out[4:0];
   end

   assign bus0.d_in = (mbc_en && bus0.a >= 16'h4000 && bus0.a <= 16'h7FFF) ? {3'b000, bank_r} : din_v;
   assign bus1.d_in = 8'h3C;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start0(input logic w, input logic [15:0] ad, input logic [7:0] wd,
                         input logic [7:0] rd_exp, input logic push);
      exp_t e;
      bus0.req   = 1'b1;
      bus0.we    = w;
      bus0.addr  = ad;
      bus0.wdata = wd;
      e.we = w; e.addr = ad; e.rdata = rd_exp;
      if (push) sb_q.push_back(e);
   endtask

   task automatic ncs_read(input logic [15:0] ad, input logic exp_ncs);
      din_v = ad[7:0] ^ 8'hC3;
      start0(1'b0, ad, 8'h00, ad[7:0] ^ 8'hC3, 1'b1);
      tick();
      bus0.req = 1'b0;
      tick();
      check("ncs_strb1", bus0.ncs, exp_ncs);
      tick();
      check("ncs_strb2", bus0.ncs, exp_ncs);
      tick();
      check("ncs_hold", bus0.ncs, 1'b1);
      tick();
   endtask

   // Scoreboard and bus-rule monitor, sampled on the falling edge
   always @(negedge clk) begin
      exp_t e;
      check("no_overlap0", (bus0.nrd === 1'b0) && (bus0.nwr === 1'b0), 1'b0);
      check("no_overlap1", (bus1.nrd === 1'b0) && (bus1.nwr === 1'b0), 1'b0);
      if (bus0.ack === 1'b1) begin
         check("sb_nonempty_at_ack", sb_q.size() != 0, 1'b1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_addr", bus0.a, e.addr);
            if (!e.we) check("sb_rdata", bus0.rdata, e.rdata);
         end
      end
   end

   initial begin
      int acks;
      int last_ack;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 16'h0000; bus0.wdata = 8'h00;
      bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = 16'h0100; bus1.wdata = 8'h00;

      // 1: reset
      repeat (3) @(posedge clk);
      #1;
      check("rst_a", bus0.a, 16'h0000);
      check("rst_nrd", bus0.nrd, 1'b1);
      check("rst_nwr", bus0.nwr, 1'b1);
      check("rst_ncs", bus0.ncs, 1'b1);
      check("rst_doe", bus0.d_oe, 1'b0);
      check("rst_ack", bus0.ack, 1'b0);
      check("rst_busy", bus0.busy, 1'b0);
      check("rst_rdata", bus0.rdata, 8'h00);
      nrst = 1'b1;
      tick(); tick();
      check("idle_busy", bus0.busy, 1'b0);
      check("idle_a", bus0.a, 16'h0000);
      check("idle_nrd", bus0.nrd, NRD_IDLE);
      check("idle_nwr", bus0.nwr, 1'b1);

      // 2: read 0x4000
      din_v = 8'h5A;
      start0(1'b0, 16'h4000, 8'h00, 8'h5A, 1'b1);
      tick();
      bus0.req = 1'b0;
      check("rd_c1_a", bus0.a, 16'h4000);
      check("rd_c1_busy", bus0.busy, 1'b1);
      check("rd_c1_nrd", bus0.nrd, NRD_IDLE);
      tick();
      check("rd_c2_nrd", bus0.nrd, 1'b0);
      check("rd_c2_ncs", bus0.ncs, 1'b1);
      check("rd_c2_ack", bus0.ack, 1'b0);
      tick();
      check("rd_c3_nrd", bus0.nrd, 1'b0);
      check("rd_c3_ack", bus0.ack, 1'b0);
      tick();
      check("rd_c4_ack", bus0.ack, 1'b1);
      check("rd_c4_rdata", bus0.rdata, 8'h5A);
      check("rd_c4_nrd", bus0.nrd, NRD_IDLE);
      check("rd_c4_busy", bus0.busy, 1'b1);
      tick();
      check("rd_c5_ack", bus0.ack, 1'b0);
      check("rd_c5_busy", bus0.busy, 1'b0);
      check("rd_c5_a", bus0.a, 16'h4000);

      // 3: write bank 5 into MBC1, read it back
      start0(1'b1, 16'h2000, 8'h05, 8'h00, 1'b1);
      tick();
      bus0.req = 1'b0;
      check("wr_c1_doe", bus0.d_oe, 1'b1);
      check("wr_c1_dout", bus0.d_out, 8'h05);
      check("wr_c1_nwr", bus0.nwr, 1'b1);
      check("wr_c1_nrd", bus0.nrd, 1'b1);
      tick();
      check("wr_c2_nwr", bus0.nwr, 1'b0);
      check("wr_c2_nrd", bus0.nrd, 1'b1);
      check("wr_c2_ncs", bus0.ncs, 1'b1);
      tick();
      check("wr_c3_nwr", bus0.nwr, 1'b0);
      check("wr_c3_dout", bus0.d_out, 8'h05);
      tick();
      check("wr_c4_nwr", bus0.nwr, 1'b1);
      check("wr_c4_doe", bus0.d_oe, 1'b1);
      check("wr_c4_ack", bus0.ack, 1'b1);
      tick();
      check("wr_c5_doe", bus0.d_oe, 1'b0);
      mbc_en = 1'b1;
      start0(1'b0, 16'h4000, 8'h00, 8'h05, 1'b1);
      tick();
      bus0.req = 1'b0;
      repeat (4) tick();
      check("mbc_bank_readback", bus0.rdata, 8'h05);
      mbc_en = 1'b0;

      // 4: chip-select window edges
      ncs_read(16'hA000, 1'b0);
      ncs_read(16'hA123, 1'b0);
      ncs_read(16'hFDFF, 1'b0);
      ncs_read(16'h9FFF, 1'b1);
      ncs_read(16'hFE00, 1'b1);

      // 5: reset during second strobe cycle of a write
      start0(1'b1, 16'h8000, 8'hA5, 8'h00, 1'b0);
      tick();
      bus0.req = 1'b0;
      tick(); tick();
      check("abort_pre_nwr", bus0.nwr, 1'b0);
      #2 nrst = 1'b0;
      #1;
      check("abort_nwr", bus0.nwr, 1'b1);
      check("abort_doe", bus0.d_oe, 1'b0);
      check("abort_busy", bus0.busy, 1'b0);
      check("abort_ack", bus0.ack, 1'b0);
      check("abort_a", bus0.a, 16'h0000);
      tick(); tick();
      nrst = 1'b1;
      repeat (3) tick();
      check("abort_no_ack", bus0.ack, 1'b0);
      din_v = 8'h77;
      start0(1'b0, 16'h0150, 8'h00, 8'h77, 1'b1);
      tick();
      bus0.req = 1'b0;
      repeat (4) tick();
      check("post_abort_rdata", bus0.rdata, 8'h77);

      // 6: back-to-back reads with one strobe cycle
      acks = 0;
      last_ack = 0;
      bus1.req = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         tick();
         if (bus1.busy === 1'b0) check("b2b_idle_nrd", bus1.nrd, NRD_IDLE);
         if (bus1.ack === 1'b1) begin
            acks++;
            if (acks == 1) check("b2b_first_ack_cycle", cyc, 3);
            else check("b2b_ack_spacing", cyc - last_ack, 4);
            check("b2b_rdata", bus1.rdata, 8'h3C);
            last_ack = cyc;
            if (acks == 3) bus1.req = 1'b0;
         end
      end
      check("b2b_ack_count", acks, 3);

      check("sb_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
